bsg_manycore_ret_responder: RTL and testbench



---
 rtl/bsg_manycore_ret_responder.sv | 158 +++++++++++++++
 tb/tb_bsg_manycore_ret_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_ret_responder.sv
// Remote-request endpoint: issues each request to local memory and queues one return packet per request.
// Optional BSG_MANYCORE_RET_ERR_CHECK_EN drops misrouted or out-of-range requests and returns err=1.

module bsg_manycore_ret_responder #(
    parameter int x_cord_width_p      = 5,
    parameter int y_cord_width_p      = 5,
    parameter int addr_width_p        = 32,
    parameter int data_width_p        = 32,
    parameter int mem_addr_width_p    = 12,
    parameter int ret_fifo_els_p      = 4,
    localparam int packet_width_lp     = 6 + 2*(x_cord_width_p+y_cord_width_p) + addr_width_p + data_width_p,
    localparam int ret_packet_width_lp = 1 + x_cord_width_p + y_cord_width_p + 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           v_i,
    input  logic [packet_width_lp-1:0]     data_i,
    output logic                           ready_o,
    output logic                           mem_v_o,
    output logic                           mem_w_o,
    output logic [mem_addr_width_p-1:0]    mem_addr_o,
    output logic [data_width_p-1:0]        mem_data_o,
    input  logic                           mem_yumi_i,
    output logic                           ret_v_o,
    output logic [ret_packet_width_lp-1:0] ret_data_o,
    input  logic                           ret_ready_i,
    input  logic [x_cord_width_p-1:0]      my_x_i,
    input  logic [y_cord_width_p-1:0]      my_y_i
);

    typedef struct packed {
        logic [5:0]                op;
        logic [y_cord_width_p-1:0] src_y;
        logic [x_cord_width_p-1:0] src_x;
        logic [y_cord_width_p-1:0] dst_y;
        logic [x_cord_width_p-1:0] dst_x;
        logic [addr_width_p-1:0]   addr;
        logic [data_width_p-1:0]   data;
    } req_pkt_s;

    typedef struct packed {
        logic                      ack;
        logic [y_cord_width_p-1:0] dst_y;
        logic [x_cord_width_p-1:0] dst_x;
        logic                      is_load;
        logic                      is_store;
        logic                      err;
        logic                      rsvd;
    } ret_pkt_s;

    localparam int ptr_w_lp = (ret_fifo_els_p > 1) ? $clog2(ret_fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(ret_fifo_els_p + 1);

    req_pkt_s pkt;
    assign pkt = data_i;

    logic                        req_v_r, req_st_r, req_drop_r;
    logic [y_cord_width_p-1:0]   req_src_y_r;
    logic [x_cord_width_p-1:0]   req_src_x_r;
    logic [mem_addr_width_p-1:0] req_addr_r;
    logic [data_width_p-1:0]     req_data_r;

    logic [cnt_w_lp-1:0] fifo_count_r;
    logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
    ret_pkt_s            fifo_mem_r [ret_fifo_els_p];

    logic     cap_drop, req_done, accept, push, pop;
    ret_pkt_s ret_push;
    logic     unused_ok;

`ifdef BSG_MANYCORE_RET_ERR_CHECK_EN
    assign cap_drop  = (pkt.dst_x != my_x_i) | (pkt.dst_y != my_y_i)
                     | (pkt.addr[addr_width_p-1:mem_addr_width_p] != '0);
    assign unused_ok = ^{pkt.op[5:1]};
`else
    assign cap_drop  = 1'b0;
    assign unused_ok = ^{pkt.op[5:1], pkt.dst_y, pkt.dst_x,
                         pkt.addr[addr_width_p-1:mem_addr_width_p], my_x_i, my_y_i};
`endif

    // A dropped request completes on its own in the cycle after capture.
    assign mem_v_o    = req_v_r & ~req_drop_r;
    assign mem_w_o    = req_st_r;
    assign mem_addr_o = req_addr_r;
    assign mem_data_o = req_data_r;
    assign req_done   = req_v_r & (req_drop_r | mem_yumi_i);

    // Reserve a FIFO slot for the held request so a push can never overflow.
    assign ready_o = (~req_v_r | req_done)
                   & ((int'(fifo_count_r) + int'(req_v_r)) < ret_fifo_els_p);
    assign accept  = v_i & ready_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_v_r     <= 1'b0;
            req_st_r    <= 1'b0;
            req_drop_r  <= 1'b0;
            req_src_y_r <= '0;
            req_src_x_r <= '0;
            req_addr_r  <= '0;
            req_data_r  <= '0;
        end else if (accept) begin
            req_v_r     <= 1'b1;
            req_st_r    <= pkt.op[0];
            req_drop_r  <= cap_drop;
            req_src_y_r <= pkt.src_y;
            req_src_x_r <= pkt.src_x;
            req_addr_r  <= pkt.addr[mem_addr_width_p-1:0];
            req_data_r  <= pkt.data;
        end else if (req_done) begin
            req_v_r <= 1'b0;
        end
    end

    always_comb begin
        ret_push          = '0;
        ret_push.ack      = 1'b1;
        ret_push.dst_y    = req_src_y_r;
        ret_push.dst_x    = req_src_x_r;
        ret_push.is_load  = ~req_st_r;
        ret_push.is_store = req_st_r;
        ret_push.err      = req_drop_r;
    end

    assign push       = req_done;
    assign pop        = ret_v_o & ret_ready_i;
    assign ret_v_o    = (fifo_count_r != '0);
    assign ret_data_o = fifo_mem_r[rd_ptr_r];

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(ret_fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
            for (int i = 0; i < ret_fifo_els_p; i++) fifo_mem_r[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem_r[wr_ptr_r] <= ret_push;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop) rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({push, pop})
                2'b10:   fifo_count_r <= fifo_count_r + 1'b1;
                2'b01:   fifo_count_r <= fifo_count_r - 1'b1;
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    always @(posedge clk_i) begin
        if (reset_n_i) assert (!(push && int'(fifo_count_r) >= ret_fifo_els_p));
    end

endmodule

// File: tb/tb_bsg_manycore_ret_responder.sv
// Directed bench for bsg_manycore_ret_responder: reset, store/load, backpressure, stall, streaming, err, mid-flight reset.

module tb_bsg_manycore_ret_responder;

    localparam int PW = 90;
    localparam int RW = 15;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          v_i = 1'b0;
    logic [PW-1:0] data_i = '0;
    logic          ready_o;
    logic          mem_v_o, mem_w_o;
    logic [11:0]   mem_addr_o;
    logic [31:0]   mem_data_o;
    logic          mem_yumi_i = 1'b0;
    logic          ret_v_o;
    logic [RW-1:0] ret_data_o;
    logic          ret_ready_i = 1'b1;
    logic [4:0]    my_x = 5'd1;
    logic [4:0]    my_y = 5'd1;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    bsg_manycore_ret_responder dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_yumi_i(mem_yumi_i), .ret_v_o(ret_v_o), .ret_data_o(ret_data_o),
        .ret_ready_i(ret_ready_i), .my_x_i(my_x), .my_y_i(my_y)
    );

    function automatic logic [PW-1:0] mk_req(input logic [5:0] op, input logic [4:0] sy, sx, dy, dx,
                                             input logic [31:0] addr, data);
        return {op, sy, sx, dy, dx, addr, data};
    endfunction

    function automatic logic [RW-1:0] mk_ret(input logic [4:0] dy, dx, input logic ld, st, er);
        return {1'b1, dy, dx, ld, st, er, 1'b0};
    endfunction

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; #3;
        vecs++; if ({ready_o, mem_v_o, mem_w_o, ret_v_o} !== 4'b1000) begin
            errs++; $display("FAIL reset_ctl got=%b exp=1000", {ready_o, mem_v_o, mem_w_o, ret_v_o}); end
        vecs++; if ({mem_addr_o, mem_data_o, ret_data_o} !== '0) begin
            errs++; $display("FAIL reset_data addr=%h data=%h ret=%h exp=0", mem_addr_o, mem_data_o, ret_data_o); end
        cyc(); cyc(); reset_n = 1'b1; cyc();
    endtask

    task automatic test_single_store();
        ret_ready_i = 1'b1; mem_yumi_i = 1'b0;
        data_i = mk_req(6'd1, 5'd3, 5'd2, 5'd1, 5'd1, 32'h10, 32'hDEADBEEF); v_i = 1'b1;
        cyc(); v_i = 1'b0;
        vecs++; if ({mem_v_o, mem_w_o, mem_addr_o, mem_data_o} !== {1'b1, 1'b1, 12'h010, 32'hDEADBEEF}) begin
            errs++; $display("FAIL store_mem v=%b w=%b a=%h d=%h exp 1 1 010 deadbeef", mem_v_o, mem_w_o, mem_addr_o, mem_data_o); end
        vecs++; if (ret_v_o !== 1'b0) begin errs++; $display("FAIL store_early_ret got=%b exp=0", ret_v_o); end
        mem_yumi_i = 1'b1; cyc(); mem_yumi_i = 1'b0;
        vecs++; if ({ret_v_o, ret_data_o} !== {1'b1, mk_ret(5'd3, 5'd2, 1'b0, 1'b1, 1'b0)}) begin
            errs++; $display("FAIL store_ret v=%b d=%h exp v=1 d=%h", ret_v_o, ret_data_o, mk_ret(5'd3, 5'd2, 1'b0, 1'b1, 1'b0)); end
        vecs++; if (mem_v_o !== 1'b0) begin errs++; $display("FAIL store_mem_clear got=%b exp=0", mem_v_o); end
        cyc();
        vecs++; if (ret_v_o !== 1'b0) begin errs++; $display("FAIL store_ret_pop got=%b exp=0", ret_v_o); end
    endtask

    task automatic test_backpressure();
        int   sent, got;
        logic acc;
        sent = 0; got = 0;
        ret_ready_i = 1'b0; mem_yumi_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            v_i = (sent < 6);
            data_i = mk_req(6'd1, 5'd5, 5'(sent), 5'd1, 5'd1, 32'(sent), 32'(sent));
            #1; acc = v_i & ready_o;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        v_i = 1'b0; #1;
        vecs++; if (sent != 4) begin errs++; $display("FAIL bp_accepted got=%0d exp=4", sent); end
        vecs++; if (ready_o !== 1'b0) begin errs++; $display("FAIL bp_ready got=%b exp=0", ready_o); end
        vecs++; if ({ret_v_o, ret_data_o} !== {1'b1, mk_ret(5'd5, 5'd0, 1'b0, 1'b1, 1'b0)}) begin
            errs++; $display("FAIL bp_head v=%b d=%h exp v=1 d=%h", ret_v_o, ret_data_o, mk_ret(5'd5, 5'd0, 1'b0, 1'b1, 1'b0)); end
        ret_ready_i = 1'b1;
        for (int c = 0; c < 30; c++) begin
            v_i = (sent < 6);
            data_i = mk_req(6'd1, 5'd5, 5'(sent), 5'd1, 5'd1, 32'(sent), 32'(sent));
            #1; acc = v_i & ready_o;
            if (ret_v_o) begin
                vecs++; if (ret_data_o !== mk_ret(5'd5, 5'(got), 1'b0, 1'b1, 1'b0)) begin
                    errs++; $display("FAIL bp_order idx=%0d got=%h exp=%h", got, ret_data_o, mk_ret(5'd5, 5'(got), 1'b0, 1'b1, 1'b0)); end
                got++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        v_i = 1'b0; mem_yumi_i = 1'b0;
        vecs++; if (got != 6 || sent != 6) begin errs++; $display("FAIL bp_total returns=%0d sent=%0d exp=6/6", got, sent); end
    endtask

    task automatic test_mem_stall();
        ret_ready_i = 1'b1; mem_yumi_i = 1'b0;
        data_i = mk_req(6'd0, 5'd6, 5'd7, 5'd1, 5'd1, 32'h2A4, 32'h1234); v_i = 1'b1;
        cyc(); v_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vecs++; if ({mem_v_o, mem_w_o, mem_addr_o, mem_data_o, ready_o, ret_v_o} !==
                        {1'b1, 1'b0, 12'h2A4, 32'h1234, 1'b0, 1'b0}) begin
                errs++; $display("FAIL stall_hold c=%0d v=%b w=%b a=%h d=%h rdy=%b rv=%b", c,
                                 mem_v_o, mem_w_o, mem_addr_o, mem_data_o, ready_o, ret_v_o); end
            cyc();
        end
        mem_yumi_i = 1'b1; #1;
        vecs++; if (ready_o !== 1'b1) begin errs++; $display("FAIL stall_ready_on_yumi got=%b exp=1", ready_o); end
        cyc(); mem_yumi_i = 1'b0;
        vecs++; if ({ret_v_o, ret_data_o} !== {1'b1, mk_ret(5'd6, 5'd7, 1'b1, 1'b0, 1'b0)}) begin
            errs++; $display("FAIL stall_load_ret v=%b d=%h exp v=1 d=%h", ret_v_o, ret_data_o, mk_ret(5'd6, 5'd7, 1'b1, 1'b0, 1'b0)); end
        cyc();
    endtask

    task automatic test_streaming();
        int got;
        got = 0;
        ret_ready_i = 1'b1; mem_yumi_i = 1'b1;
        for (int c = 0; c < 14; c++) begin
            v_i = (c < 8);
            data_i = mk_req(6'(c & 1), 5'(c), 5'(c + 8), 5'd1, 5'd1, 32'(c * 4), 32'(c));
            #1;
            if (c < 8) begin
                vecs++; if (ready_o !== 1'b1) begin errs++; $display("FAIL stream_ready c=%0d got=%b exp=1", c, ready_o); end
            end
            if (ret_v_o) begin
                vecs++; if (ret_data_o !== mk_ret(5'(got), 5'(got + 8), ~got[0], got[0], 1'b0) || c != got + 2) begin
                    errs++; $display("FAIL stream_ret idx=%0d cyc=%0d got=%h exp=%h at cyc %0d", got, c, ret_data_o,
                                     mk_ret(5'(got), 5'(got + 8), ~got[0], got[0], 1'b0), got + 2); end
                got++;
            end
            @(posedge clk); #1;
        end
        v_i = 1'b0; mem_yumi_i = 1'b0;
        vecs++; if (got != 8) begin errs++; $display("FAIL stream_count got=%0d exp=8", got); end
    endtask

    task automatic test_err_check();
        ret_ready_i = 1'b1; mem_yumi_i = 1'b0;
        data_i = mk_req(6'd1, 5'd2, 5'd2, 5'd4, 5'd4, 32'h8, 32'h55); v_i = 1'b1;
        cyc(); v_i = 1'b0;
`ifdef BSG_MANYCORE_RET_ERR_CHECK_EN
        vecs++; if ({mem_v_o, ret_v_o} !== 2'b00) begin errs++; $display("FAIL err_cap mem_v=%b ret_v=%b exp 0 0", mem_v_o, ret_v_o); end
        cyc();
        vecs++; if ({mem_v_o, ret_v_o, ret_data_o} !== {1'b0, 1'b1, mk_ret(5'd2, 5'd2, 1'b0, 1'b1, 1'b1)}) begin
            errs++; $display("FAIL err_ret mem_v=%b ret_v=%b d=%h exp 0 1 %h", mem_v_o, ret_v_o, ret_data_o, mk_ret(5'd2, 5'd2, 1'b0, 1'b1, 1'b1)); end
`else
        vecs++; if ({mem_v_o, mem_w_o, mem_addr_o, mem_data_o} !== {1'b1, 1'b1, 12'h008, 32'h55}) begin
            errs++; $display("FAIL noerr_mem v=%b w=%b a=%h d=%h exp 1 1 008 55", mem_v_o, mem_w_o, mem_addr_o, mem_data_o); end
        mem_yumi_i = 1'b1; cyc(); mem_yumi_i = 1'b0;
        vecs++; if ({ret_v_o, ret_data_o} !== {1'b1, mk_ret(5'd2, 5'd2, 1'b0, 1'b1, 1'b0)}) begin
            errs++; $display("FAIL noerr_ret v=%b d=%h exp 1 %h", ret_v_o, ret_data_o, mk_ret(5'd2, 5'd2, 1'b0, 1'b1, 1'b0)); end
`endif
        cyc();
    endtask

    task automatic test_reset_mid();
        ret_ready_i = 1'b0; mem_yumi_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v_i = 1'b1; data_i = mk_req(6'd1, 5'd1, 5'(k), 5'd1, 5'd1, 32'(k), 32'(k));
            cyc();
        end
        v_i = 1'b0; mem_yumi_i = 1'b0; #1;
        vecs++; if ({mem_v_o, ret_v_o, ready_o} !== 3'b110) begin
            errs++; $display("FAIL mid_pre got=%b exp=110", {mem_v_o, ret_v_o, ready_o}); end
        #2; reset_n = 1'b0; #1;
        vecs++; if ({ready_o, mem_v_o, mem_w_o, ret_v_o} !== 4'b1000) begin
            errs++; $display("FAIL mid_reset_ctl got=%b exp=1000", {ready_o, mem_v_o, mem_w_o, ret_v_o}); end
        vecs++; if ({mem_addr_o, mem_data_o, ret_data_o} !== '0) begin
            errs++; $display("FAIL mid_reset_data addr=%h data=%h ret=%h exp=0", mem_addr_o, mem_data_o, ret_data_o); end
        cyc(); cyc(); reset_n = 1'b1; ret_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            vecs++; if ({mem_v_o, ret_v_o} !== 2'b00) begin
                errs++; $display("FAIL mid_stale c=%0d mem_v=%b ret_v=%b exp 0 0", c, mem_v_o, ret_v_o); end
        end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_backpressure();
        test_mem_stall();
        test_streaming();
        test_err_check();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
